// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: fetch PC, credit-limited imem requests, in-order response queue to decode.
// Optional TRIREME_FETCH_MISALIGN_EN adds fetch_misaligned and stalls fetch on unaligned redirects.
module fetch_queue_unit #(
  parameter int CORE = 0,
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_BITS = 32,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC = '0,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    redirect,
  input  logic [ADDRESS_BITS-1:0] redirect_target,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [ADDRESS_BITS-1:0] imem_req_addr,
  input  logic                    imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   imem_rsp_data,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [ADDRESS_BITS-1:0] PC,
  output logic [DATA_WIDTH-1:0]   instruction,
`ifdef TRIREME_FETCH_MISALIGN_EN
  output logic                    fetch_misaligned,
`endif
  input  logic                    scan
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int AW = $clog2(QUEUE_DEPTH);
  logic [ADDRESS_BITS-1:0] fetch_pc, rsp_pc, target;
  logic [CW-1:0] outstanding, drop, count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [ADDRESS_BITS-1:0] pc_q [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] data_q [QUEUE_DEPTH];
  logic misaligned, req_fire, push, pop, unused_bits;
`ifdef TRIREME_FETCH_MISALIGN_EN
  assign target = redirect_target;
  always_ff @(posedge clock or posedge reset)
    if (reset) misaligned <= 1'b0;
    else if (redirect) misaligned <= redirect_target[1:0] != 2'b00;
  assign fetch_misaligned = misaligned;
`else
  assign target = {redirect_target[ADDRESS_BITS-1:2], 2'b00};
  assign misaligned = 1'b0;
`endif
  assign unused_bits = ^{scan, redirect_target[1:0], CORE != 0};
  // Credits cover both queued and in-flight words, so the queue can never overflow
  assign imem_req_valid = !reset && !redirect && !misaligned &&
                          ({1'b0, outstanding} + {1'b0, count} < (CW+1)'(QUEUE_DEPTH));
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign push = imem_rsp_valid && drop == '0 && !redirect;
  assign inst_valid = count != '0;
  assign pop = inst_valid && inst_ready;
  assign PC = inst_valid ? pc_q[rd_ptr] : '0;
  assign instruction = inst_valid ? data_q[rd_ptr] : DATA_WIDTH'(32'h00000013);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect) begin
        fetch_pc <= target;
        rsp_pc <= target;
        drop <= outstanding - CW'(imem_rsp_valid);
        count <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + ADDRESS_BITS'(4);
        if (imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
        if (push) rsp_pc <= rsp_pc + ADDRESS_BITS'(4);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  always_ff @(posedge clock)
    if (push) begin
      pc_q[wr_ptr] <= rsp_pc;
      data_q[wr_ptr] <= imem_rsp_data;
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed bench for fetch_queue_unit with a 1..3 cycle in-order memory model.
module tb_fetch_queue_unit;
  logic clock = 1'b0, reset = 1'b1, redirect = 1'b0, imem_req_ready = 1'b1, inst_ready = 1'b1, scan = 1'b0;
  logic [31:0] redirect_target = '0;
  logic imem_req_valid, imem_rsp_valid, inst_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, PC, instruction;
`ifdef TRIREME_FETCH_MISALIGN_EN
  logic fetch_misaligned;
`endif
  int errors = 0, checks = 0, lat = 1, n;
  logic v1, v2, v3;
  logic [31:0] a1, a2, a3;

  fetch_queue_unit dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .PC(PC), .instruction(instruction),
`ifdef TRIREME_FETCH_MISALIGN_EN
    .fetch_misaligned(fetch_misaligned),
`endif
    .scan(scan)
  );

  always #5 clock = ~clock;

  // Memory returns the bitwise complement of the address after lat cycles
  always @(posedge clock or posedge reset)
    if (reset) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
    end else begin
      v1 <= imem_req_valid && imem_req_ready; a1 <= imem_req_addr;
      v2 <= v1; a2 <= a1;
      v3 <= v2; a3 <= a2;
    end
  assign imem_rsp_valid = lat == 1 ? v1 : lat == 2 ? v2 : v3;
  assign imem_rsp_data = ~(lat == 1 ? a1 : lat == 2 ? a2 : a3);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #3;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #1;
    check("reset_inst_valid", 32'(inst_valid), 32'd0);
    check("reset_req_valid", 32'(imem_req_valid), 32'd0);
    tick;
    tick;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #3;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_instruction", instruction, 32'h00000013);
    check("rst_pc", PC, 32'h0);
    tick;
    tick;
    reset = 1'b0;
    #1;
    // streaming with 1-cycle memory
    check("c0_req_valid", 32'(imem_req_valid), 32'd1);
    check("c0_addr", imem_req_addr, 32'h0);
    check("c0_inst_valid", 32'(inst_valid), 32'd0);
    tick;
    check("c1_addr", imem_req_addr, 32'h4);
    check("c1_inst_valid", 32'(inst_valid), 32'd0);
    tick;
    check("c2_addr", imem_req_addr, 32'h8);
    check("c2_inst_valid", 32'(inst_valid), 32'd1);
    check("c2_pc", PC, 32'h0);
    check("c2_inst", instruction, ~32'h0);
    tick;
    check("c3_pc", PC, 32'h4);
    check("c3_inst", instruction, ~32'h4);
    tick;
    check("c4_pc", PC, 32'h8);
    check("c4_inst", instruction, ~32'h8);
    // decode stalled: credits cap requests at queue depth
    inst_ready = 1'b0;
    do_reset;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_valid && imem_req_ready) n++;
      tick;
    end
    check("stall_req_count", 32'(n), 32'd4);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_inst_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    #1;
    check("drain_pc0", PC, 32'h0);
    tick;
    check("drain_pc4", PC, 32'h4);
    tick;
    check("drain_pc8", PC, 32'h8);
    tick;
    check("drain_pcC", PC, 32'hC);
    tick;
    check("drain_pc10", PC, 32'h10);
    check("drain_inst10", instruction, ~32'h10);
    // 3-cycle memory, redirect with three in flight
    lat = 3;
    do_reset;
    tick;
    tick;
    tick;
    redirect = 1'b1;
    redirect_target = 32'h100;
    #1;
    check("r1_req_valid", 32'(imem_req_valid), 32'd0);
    tick;
    redirect = 1'b0;
    #1;
    check("r1_next_req_valid", 32'(imem_req_valid), 32'd1);
    check("r1_next_addr", imem_req_addr, 32'h100);
    check("r1_c4_inst_valid", 32'(inst_valid), 32'd0);
    for (int i = 5; i < 8; i++) begin
      tick;
      check("r1_no_old_data", 32'(inst_valid), 32'd0);
    end
    tick;
    check("r1_pc", PC, 32'h100);
    check("r1_inst", instruction, ~32'h100);
    tick;
    check("r1_pc_next", PC, 32'h104);
    // redirect coinciding with a response and a pop
    lat = 1;
    do_reset;
    tick;
    tick;
    tick;
    redirect = 1'b1;
    redirect_target = 32'h200;
    #1;
    check("r2_pop_head", PC, 32'h4);
    check("r2_req_valid", 32'(imem_req_valid), 32'd0);
    tick;
    redirect = 1'b0;
    #1;
    check("r2_inst_valid", 32'(inst_valid), 32'd0);
    check("r2_req_valid_next", 32'(imem_req_valid), 32'd1);
    check("r2_addr", imem_req_addr, 32'h200);
    tick;
    check("r2_c5_inst_valid", 32'(inst_valid), 32'd0);
    tick;
    check("r2_pc", PC, 32'h200);
    check("r2_inst", instruction, ~32'h200);
    // memory not ready: address held
    tick;
    imem_req_ready = 1'b0;
    #1;
    check("hold_req_valid", 32'(imem_req_valid), 32'd1);
    check("hold_addr", imem_req_addr, 32'h20C);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("hold_addr_loop", imem_req_addr, 32'h20C);
    end
    check("hold_empty", 32'(inst_valid), 32'd0);
    tick;
    imem_req_ready = 1'b1;
    #1;
    check("hold_release_addr", imem_req_addr, 32'h20C);
    tick;
    check("hold_next_addr", imem_req_addr, 32'h210);
    tick;
    check("hold_pc", PC, 32'h20C);
    // unaligned redirect
    redirect = 1'b1;
    redirect_target = 32'h102;
    #1;
    check("m_redirect_req_valid", 32'(imem_req_valid), 32'd0);
    tick;
    redirect = 1'b0;
    #1;
`ifdef TRIREME_FETCH_MISALIGN_EN
    check("m_flag_set", 32'(fetch_misaligned), 32'd1);
    check("m_req_suppressed", 32'(imem_req_valid), 32'd0);
    tick;
    check("m_req_still_suppressed", 32'(imem_req_valid), 32'd0);
    redirect = 1'b1;
    redirect_target = 32'h104;
    #1;
    tick;
    redirect = 1'b0;
    #1;
    check("m_flag_clear", 32'(fetch_misaligned), 32'd0);
    check("m_resume_valid", 32'(imem_req_valid), 32'd1);
    check("m_resume_addr", imem_req_addr, 32'h104);
    tick;
    tick;
    check("m_pc", PC, 32'h104);
`else
    check("m_aligned_valid", 32'(imem_req_valid), 32'd1);
    check("m_aligned_addr", imem_req_addr, 32'h100);
    check("m_inst_valid", 32'(inst_valid), 32'd0);
    tick;
    check("m_c16_inst_valid", 32'(inst_valid), 32'd0);
    tick;
    check("m_pc", PC, 32'h100);
    check("m_inst", instruction, ~32'h100);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
